// File: rtl/float_to_fixed_conv_iter.sv
// Iterative IEEE-754 float to signed fixed-point converter. It shifts one bit per cycle and saturates on overflow.
// Optional feature: define ROUND_NEAREST_EN to round half-to-even; otherwise the magnitude is truncated.
module float_to_fixed_conv_iter #(
   parameter int EW   = 8,
   parameter int MW   = 23,
   parameter int FW   = 32,
   parameter int FRAC = 16
) (
   input  logic             CLK,
   input  logic             RST_FF,
   input  logic             Begin_FSM_FF,
   input  logic [EW+MW:0]   FLOAT_IN,
   output logic [FW-1:0]    FIXED_OUT,
   output logic             ACK_FF,
   output logic             BUSY,
   output logic             OVF,
   output logic             INVALID
);

   localparam int BIAS  = 2**(EW-1) - 1;
   localparam int MAXSH = ((FW - 2 - MW) > (MW + 1)) ? (FW - 2 - MW) : (MW + 1);
   localparam int CW    = $clog2(MAXSH) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ANALYZE, S_SHIFT, S_ROUND, S_SIGN, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [EW+MW:0]     fl_q, fl_d;
   logic [FW-1:0]      mag_q, mag_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               g_q, g_d, s_q, s_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic               inv_q, inv_d;
   logic [FW-1:0]      fixed_q, fixed_d;

   logic               sign_f;
   logic [EW-1:0]      exp_f;
   logic [MW-1:0]      mant_f;
   logic signed [31:0] d_s;

   assign sign_f = fl_q[EW+MW];
   assign exp_f  = fl_q[MW +: EW];
   assign mant_f = fl_q[MW-1:0];
   // Net left shift that brings {1,mant} onto the fixed-point grid.
   assign d_s    = $signed({{(32-EW){1'b0}}, exp_f}) - BIAS - MW + FRAC;

`ifdef ROUND_NEAREST_EN
   logic [FW:0] sum_w, lim_w;
   assign sum_w = {1'b0, mag_q} + (FW+1)'(1);
   assign lim_w = sign_f ? ((FW+1)'(1) << (FW-1)) : (((FW+1)'(1) << (FW-1)) - (FW+1)'(1));
`endif

   always_comb begin
      state_d = state_q;
      fl_d    = fl_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      g_d     = g_q;
      s_d     = s_q;
      sat_d   = sat_q;
      ovf_d   = ovf_q;
      inv_d   = inv_q;
      fixed_d = fixed_q;
      case (state_q)
         S_IDLE: begin
            if (Begin_FSM_FF) state_d = S_LOAD;
         end
         S_LOAD: begin
            fl_d    = FLOAT_IN;
            ovf_d   = 1'b0;
            inv_d   = 1'b0;
            sat_d   = 1'b0;
            state_d = S_ANALYZE;
         end
         S_ANALYZE: begin
            // Every path passes through ROUND so latency is always 4 + shift count.
            g_d     = 1'b0;
            s_d     = 1'b0;
            mag_d   = '0;
            state_d = S_ROUND;
            if (exp_f == '1) begin
               if (mant_f != '0) begin
                  inv_d = 1'b1;
               end else begin
                  sat_d = 1'b1;
                  ovf_d = 1'b1;
               end
            end else if (exp_f == '0) begin
               mag_d = '0;
            end else if (d_s >= 0 && d_s + MW > FW - 2) begin
               if (sign_f && mant_f == '0 && d_s + MW == FW - 1) begin
                  mag_d[FW-1] = 1'b1;
               end else begin
                  sat_d = 1'b1;
                  ovf_d = 1'b1;
               end
            end else if (-d_s >= MW + 2) begin
               mag_d = '0;
            end else begin
               mag_d[MW:0] = {1'b1, mant_f};
               left_d      = (d_s > 0);
               cnt_d       = CW'(d_s < 0 ? -d_s : d_s);
               if (d_s != 0) state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d = mag_q >> 1;
               g_d   = mag_q[0];
               s_d   = s_q | g_q;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_ROUND;
         end
         S_ROUND: begin
`ifdef ROUND_NEAREST_EN
            if (!sat_q && g_q && (s_q || mag_q[0])) begin
               if (sum_w > lim_w) begin
                  sat_d = 1'b1;
                  ovf_d = 1'b1;
               end else begin
                  mag_d = sum_w[FW-1:0];
               end
            end
`endif
            state_d = S_SIGN;
         end
         S_SIGN: begin
            if (sat_q) fixed_d = sign_f ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
            else       fixed_d = sign_f ? -mag_q : mag_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!Begin_FSM_FF) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST_FF) begin
         state_q <= S_IDLE;
         fl_q    <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         g_q     <= 1'b0;
         s_q     <= 1'b0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
         fixed_q <= '0;
      end else begin
         state_q <= state_d;
         fl_q    <= fl_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         g_q     <= g_d;
         s_q     <= s_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
         fixed_q <= fixed_d;
      end
   end

   assign FIXED_OUT = fixed_q;
   assign ACK_FF    = (state_q == S_DONE);
   assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign OVF       = ovf_q;
   assign INVALID   = inv_q;

endmodule

// File: tb/tb_float_to_fixed_conv_iter.sv
// Self-checking bench for float_to_fixed_conv_iter with default parameters; the expected queue holds {OVF, INVALID, FIXED_OUT}.
module tb_float_to_fixed_conv_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        begin_i = 1'b0;
   logic [31:0] float_i = '0;
   logic [31:0] fixed_o;
   logic        ack_o, busy_o, ovf_o, inv_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];

   always #5 clk = ~clk;

   float_to_fixed_conv_iter dut (
      .CLK          (clk),
      .RST_FF       (rst),
      .Begin_FSM_FF (begin_i),
      .FLOAT_IN     (float_i),
      .FIXED_OUT    (fixed_o),
      .ACK_FF       (ack_o),
      .BUSY         (busy_o),
      .OVF          (ovf_o),
      .INVALID      (inv_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: exact value m24 * 2^(e-134), rounded from the full remainder.
   function automatic logic [33:0] model(input logic [31:0] f);
      logic sgn, ovf, inv;
      int e, d, sh;
      longint unsigned m, q, rem, half, lim;
      logic [31:0] r;
      sgn = f[31];
      e   = int'(f[30:23]);
      m   = {40'd0, 1'b1, f[22:0]};
      ovf = 1'b0;
      inv = 1'b0;
      q   = 0;
      lim = sgn ? 64'h8000_0000 : 64'h7FFF_FFFF;
      if (e == 255 && f[22:0] != 0) inv = 1'b1;
      else if (e == 255) ovf = 1'b1;
      else if (e != 0) begin
         d = e - 134;
         if (d >= 0) begin
            if (d >= 40) ovf = 1'b1;
            else begin
               q = m << d;
               if (q > lim) ovf = 1'b1;
            end
         end else begin
            sh = -d;
            if (sh < 63) begin
               q    = m >> sh;
               rem  = m & ((64'd1 << sh) - 1);
               half = 64'd1 << (sh - 1);
`ifdef ROUND_NEAREST_EN
               if (rem > half || (rem == half && q[0])) q = q + 1;
`else
               if (rem > half) q = q;
`endif
               if (q > lim) ovf = 1'b1;
            end
         end
      end
      if (ovf)      r = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else if (inv) r = 32'h0;
      else          r = sgn ? -q[31:0] : q[31:0];
      return {ovf, inv, r};
   endfunction

   function automatic int lat_model(input logic [31:0] f);
      int e, d;
      e = int'(f[30:23]);
      if (e == 0 || e == 255) return 4;
      d = e - 134;
      if (d > 7) return 4;
      if (d >= 0) return 4 + d;
      if (-d >= 25) return 4;
      return 4 - d;
   endfunction

   task automatic run_conv(input logic [31:0] f, input bit toggle);
      int lat;
      logic [33:0] e;
      exp_q.push_back(model(f));
      @(negedge clk);
      begin_i = 1'b1;
      float_i = f;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (k == 0) check("busy_load", 64'(busy_o), 64'd1);
         if (ack_o) begin
            lat = k;
            break;
         end
         if (toggle && k >= 1 && k <= 5) begin_i = ~begin_i;
         if (toggle && k == 6) begin_i = 1'b1;
      end
      if (lat < 0) check("ack_timeout", 64'd0, 64'd1);
      check("latency", 64'(lat), 64'(lat_model(f)));
      e = exp_q.pop_front();
      check("result", 64'({ovf_o, inv_o, fixed_o}), 64'(e));
      check("busy_done", 64'(busy_o), 64'd0);
      // Begin held high in DONE must not restart.
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check("ack_hold", 64'({ack_o, busy_o}), 64'b10);
      end
      @(negedge clk);
      begin_i = 1'b0;
      @(posedge clk); #1;
      check("ack_fall", 64'({ack_o, busy_o}), 64'b00);
   endtask

   initial begin
      int acks;
      logic [31:0] f;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", 64'({fixed_o, ack_o, busy_o, ovf_o, inv_o}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_conv(32'h3F80_0000, 1'b0);   // 1.0
      run_conv(32'hC020_0000, 1'b0);   // -2.5
      run_conv(32'h4700_0000, 1'b0);   // 32768.0 saturates
      run_conv(32'hC700_0000, 1'b0);   // -32768.0 exact minimum
      run_conv(32'h7FC0_0000, 1'b0);   // NaN
      run_conv(32'h7F80_0000, 1'b0);   // +inf
      run_conv(32'h0000_0001, 1'b0);   // denormal
      run_conv(32'h37C0_0000, 1'b0);   // 1.5 LSB
      run_conv(32'h3700_0000, 1'b0);   // 0.5 LSB
      run_conv(32'h3700_0001, 1'b0);   // just above 0.5 LSB
      run_conv(32'h36FF_FFFF, 1'b0);   // below the shift window
      run_conv(32'h4680_0000, 1'b0);   // 16384.0, longest left shift
      run_conv(32'h46FF_FFFF, 1'b0);   // largest in-range positive
      run_conv(32'hC6FF_FFFF, 1'b0);
      run_conv(32'h3F80_0000, 1'b1);   // Begin toggled while busy
      for (int i = 0; i < 24; i++) begin
         f = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 145)), 23'($urandom)};
         run_conv(f, 1'b0);
      end

      // Leave a nonzero result and OVF set, then abort a conversion mid-shift.
      run_conv(32'hFF80_0000, 1'b0);   // -inf
      @(negedge clk);
      begin_i = 1'b1;
      float_i = 32'h3F80_0000;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst     = 1'b1;
      begin_i = 1'b0;
      @(posedge clk); #1;
      check("reset_mid", 64'({fixed_o, ack_o, busy_o, ovf_o, inv_o}), 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      acks = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (ack_o || busy_o) acks++;
      end
      check("no_ack_after_abort", 64'(acks), 64'd0);

      run_conv(32'hBF80_0000, 1'b0);   // -1.0 after reset

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
